// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider sequencer: glitch-free runtime divisor changes and
// start/stop on period boundaries. Optional 50% duty for odd N: DIV_ODD_DUTY50_EN.
module clk_div_ctrl #(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic [W-1:0] cur_div,
    output logic         div_clk,
    output logic         div_tick,
    output logic         running
);

    localparam logic [W-1:0] DefDiv = W'(DEFAULT_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
    logic         cfg_err_q, cfg_err_d;
    logic         div_clk_q, div_clk_d;
    logic         div_tick_q, div_tick_d;

    logic active;
    logic tc;
    logic accept;
    logic legal;

    assign active = (state_q != StIdle);
    assign tc     = (cnt_q == cur_div_q - W'(1));
    assign accept = cfg_valid && cfg_ready;
    assign legal  = (cfg_div >= W'(2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StRun;
            StRun:  if (!en) state_d = StStop;
            StStop: begin
                if (en) begin
                    state_d = StRun;
                end else if (tc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d        = '0;
        cur_div_d    = cur_div_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = accept && !legal;

        if (active && !tc) begin
            cnt_d = cnt_q + W'(1);
        end

        // Pending load happens before acceptance so a same-cycle accept waits a full period
        if (active && tc && pend_valid_q) begin
            cur_div_d    = pend_q;
            pend_valid_d = 1'b0;
        end

        if (accept && legal) begin
            if (!active) begin
                cur_div_d = cfg_div;
            end else begin
                pend_d       = cfg_div;
                pend_valid_d = 1'b1;
            end
        end

        div_clk_d  = (state_d != StIdle) && (cnt_d < (cur_div_d >> 1));
        div_tick_d = (state_d != StIdle) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            cur_div_q    <= DefDiv;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            div_clk_q    <= 1'b0;
            div_tick_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_div_q    <= cur_div_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
            div_clk_q    <= div_clk_d;
            div_tick_q   <= div_tick_d;
        end
    end

`ifdef DIV_ODD_DUTY50_EN
    // Half-cycle delayed copy stretches the high phase of odd divisors to N/2 cycles
    logic neg_q;

    always_ff @(negedge clk) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else if (!active || !cur_div_q[0]) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= div_clk_q;
        end
    end

    always_comb begin
        div_clk = div_clk_q | neg_q;
    end
`else
    always_comb begin
        div_clk = div_clk_q;
    end
`endif

    always_comb begin
        running   = active;
        cfg_ready = !pend_valid_q;
        cfg_err   = cfg_err_q;
        cur_div   = cur_div_q;
        div_tick  = div_tick_q;
    end

endmodule
